ahb3lite_gpio: RTL and testbench
================================

// Module: ahb3lite_gpio
// PURPOSE
//  Parametrised AHB3-Lite GPIO slave; generalises hard-wired LED/push-button handling in the soft-MC top.
//  Per-pin direction, set/clear/toggle output writes, synchronised inputs, rise/fall edge IRQ with mask/pending.
//  Sits on one interconnect slave port; gpio_o/gpio_oe_o drive board pins (LEDs), gpio_i from buttons.
// PARAMETERS
//  HADDR_SIZE   32  AHB address width
//  HDATA_SIZE   32  AHB data width (only 32 supported)
//  GPIO_WIDTH   8   number of pins, 1..32
//  SYNC_STAGES  2   input synchroniser depth, >=2
// PORTS
//  HCLK       in   1           AHB clock; single clock domain
//  HRESETn    in   1           reset, asynchronous assert, active-low
//  HSEL       in   1           slave select
//  HADDR      in   HADDR_SIZE  address; HADDR[5:2] = register index
//  HWDATA     in   HDATA_SIZE  write data (data phase)
//  HRDATA     out  HDATA_SIZE  read data
//  HWRITE     in   1           1=write
//  HSIZE      in   3           transfer size (byte/half/word)
//  HBURST     in   3           ignored
//  HPROT      in   4           ignored
//  HTRANS     in   2           IDLE/BUSY/NONSEQ/SEQ
//  HREADY     in   1           bus ready; address phase sampled only when 1
//  HREADYOUT  out  1           slave ready
//  HRESP      out  1           0=OKAY, 1=ERROR
//  gpio_i     in   GPIO_WIDTH  asynchronous pin inputs
//  gpio_o     out  GPIO_WIDTH  output data
//  gpio_oe_o  out  GPIO_WIDTH  output enable (=DIR)
//  irq_o      out  1           |(PEND & MASK), registered
// BEHAVIOUR
//  Reset: HRDATA=0, HREADYOUT=1, HRESP=0, gpio_o=0, gpio_oe_o=0, irq_o=0; all registers 0; sync chain 0.
//  Map (word offset): 0 OUT rw | 1 IN ro | 2 DIR rw | 3 MASK rw | 4 RISE_EN rw | 5 FALL_EN rw
//   6 PEND r/w1c | 7 SET wo (OUT|=d) | 8 CLR wo (OUT&=~d) | 9 TGL wo (OUT^=d); idx 10..15 unmapped.
//  Address phase: HSEL&HREADY&HTRANS[1] latches idx, HWRITE, HSIZE, HADDR[1:0]; BUSY/IDLE -> no access.
//  Write: applied at end of data phase with HWDATA; byte-lane enables from HSIZE/HADDR[1:0]; bits >=GPIO_WIDTH ignored.
//  Read: HRDATA valid in data phase, zero wait states; reads of SET/CLR/TGL return 0; unused bits read 0.
//  IN read = last sync stage; input latency SYNC_STAGES cycles pin->IN.
//  Edge: rise = sync & ~prev, fall = ~sync & prev; PEND |= (rise&RISE_EN)|(fall&FALL_EN) each cycle.
//  Simultaneous W1C and new edge on same bit: set wins (PEND stays 1).
//  irq_o registered: asserts 1 cycle after PEND&MASK !=0; deasserts 1 cycle after cleared.
//  Error FSM: OKAY -> ERR1 -> ERR2 -> OKAY. Unmapped idx, write to IN, or read of SET/CLR/TGL... no: only
//   unmapped idx and write to IN raise ERROR. ERR1: HREADYOUT=0,HRESP=1; ERR2: HREADYOUT=1,HRESP=1; no register change.
//  Pins written through DIR=0 still update OUT; gpio_o shows OUT regardless; oe gates the pad.
//  Reset mid-transfer: FSM to OKAY, registers cleared, pending access dropped.
// STRUCTURE
//  Package ahb3lite_gpio_pkg: register index localparams, HTRANS_*/HSIZE_*/HRESP_* constants,
//   typedef enum {ST_OKAY,ST_ERR1,ST_ERR2} gpio_resp_state_t, function be_from_size().
//  Sub-module gpio_edge_detect #(WIDTH,SYNC_STAGES): synchroniser + prev register, outputs sync/rise/fall.
// TESTING
//  Reset released, read idx0..6 -> all 0, HREADYOUT=1, HRESP=0, irq_o=0.
//  W DIR=0xFF, OUT=0xA5, SET=0x02, CLR=0x80, TGL=0x0F -> gpio_o=0x28, gpio_oe_o=0xFF, read OUT=0x28.
//  Byte write HSIZE=0 addr 0x01 data 0x0000_5500 to OUT (WIDTH=16) -> OUT=0x5500|prev low byte kept.
//  RISE_EN=0x01,MASK=0x01, gpio_i[0] 0->1 -> PEND[0]=1 after SYNC_STAGES+1, irq_o next cycle; W1C 0x01 -> irq_o=0.
//  W1C on PEND[0] same cycle as new rise on pin0 -> PEND[0] stays 1, irq_o stays 1.
//  Read idx 12 / write IN -> HREADYOUT 0 then 1 with HRESP=1 both cycles; no register changes; back-to-back OK after.

Source files
------------

// File: rtl/ahb3lite_gpio_pkg.sv
// rtl/ahb3lite_gpio_pkg.sv - shared constants, types and helpers for the AHB3-Lite GPIO slave
// Contents: register word indices, HTRANS/HSIZE/HRESP encodings, error-response FSM state type,
//           byte-lane enable helper.
package ahb3lite_gpio_pkg;

  localparam logic [3:0] REG_OUT     = 4'd0;
  localparam logic [3:0] REG_IN      = 4'd1;
  localparam logic [3:0] REG_DIR     = 4'd2;
  localparam logic [3:0] REG_MASK    = 4'd3;
  localparam logic [3:0] REG_RISE_EN = 4'd4;
  localparam logic [3:0] REG_FALL_EN = 4'd5;
  localparam logic [3:0] REG_PEND    = 4'd6;
  localparam logic [3:0] REG_SET     = 4'd7;
  localparam logic [3:0] REG_CLR     = 4'd8;
  localparam logic [3:0] REG_TGL     = 4'd9;
  localparam logic [3:0] REG_LAST    = REG_TGL;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OKAY,
    ST_ERR1,
    ST_ERR2
  } gpio_resp_state_t;

  // Byte-lane enables for a 32-bit data bus; sizes wider than a word are treated as a word.
  function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/gpio_edge_detect.sv
// rtl/gpio_edge_detect.sv - input synchroniser with rise/fall edge detection
// Ports: clk, rst_n (async active-low), pin (async inputs),
//        sync (last synchroniser stage), rise/fall (one-cycle edge pulses on sync).
module gpio_edge_detect #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/ahb3lite_gpio.sv
// rtl/ahb3lite_gpio.sv - AHB3-Lite GPIO slave with direction, set/clear/toggle and edge interrupts
// Ports: HCLK/HRESETn (async active-low), AHB3-Lite slave port (HSEL..HRESP, HBURST/HPROT unused),
//        gpio_i (async pins), gpio_o (OUT), gpio_oe_o (DIR), irq_o (registered |(PEND & MASK)).
module ahb3lite_gpio #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int GPIO_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);
  import ahb3lite_gpio_pkg::*;

  logic [GPIO_WIDTH-1:0] out_r, dir_r, mask_r, rise_en_r, fall_en_r, pend_r;
  logic [GPIO_WIDTH-1:0] in_sync, in_rise, in_fall;

  logic             dp_valid, dp_write;
  logic [3:0]       dp_idx;
  logic [2:0]       dp_size;
  logic [1:0]       dp_alo;
  gpio_resp_state_t state;

  logic [3:0]            a_idx;
  logic                  acc, acc_err, wr_en;
  logic [3:0]            be;
  logic [31:0]           lane_mask;
  logic [GPIO_WIDTH-1:0] wmask, wdata, rd;
  logic                  unused_ok;

  gpio_edge_detect #(
    .WIDTH       (GPIO_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .pin   (gpio_i),
    .sync  (in_sync),
    .rise  (in_rise),
    .fall  (in_fall)
  );

  assign a_idx   = HADDR[5:2];
  assign acc     = HSEL & HREADY & (HTRANS != HTRANS_IDLE) & (HTRANS != HTRANS_BUSY);
  // Illegal accesses never become a data phase; the response FSM handles them alone.
  assign acc_err = acc & ((a_idx > REG_LAST) | (HWRITE & (a_idx == REG_IN)));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_size  <= '0;
      dp_alo   <= '0;
    end else if (HREADY) begin
      dp_valid <= acc & ~acc_err;
      dp_write <= HWRITE;
      dp_idx   <= a_idx;
      dp_size  <= HSIZE;
      dp_alo   <= HADDR[1:0];
    end
  end

  always_comb begin
    be        = be_from_size(dp_size, dp_alo);
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  assign wmask = lane_mask[GPIO_WIDTH-1:0];
  assign wdata = HWDATA[GPIO_WIDTH-1:0] & wmask;
  assign wr_en = dp_valid & dp_write & HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      out_r     <= '0;
      dir_r     <= '0;
      mask_r    <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
      pend_r    <= '0;
      irq_o     <= 1'b0;
    end else begin
      // New edges are OR-ed in after the W1C so a same-cycle edge keeps its pending bit.
      pend_r <= ((wr_en && dp_idx == REG_PEND) ? (pend_r & ~wdata) : pend_r)
              | (in_rise & rise_en_r) | (in_fall & fall_en_r);
      irq_o  <= |(pend_r & mask_r);
      if (wr_en) begin
        case (dp_idx)
          REG_OUT:     out_r     <= (out_r & ~wmask) | wdata;
          REG_DIR:     dir_r     <= (dir_r & ~wmask) | wdata;
          REG_MASK:    mask_r    <= (mask_r & ~wmask) | wdata;
          REG_RISE_EN: rise_en_r <= (rise_en_r & ~wmask) | wdata;
          REG_FALL_EN: fall_en_r <= (fall_en_r & ~wmask) | wdata;
          REG_SET:     out_r     <= out_r | wdata;
          REG_CLR:     out_r     <= out_r & ~wdata;
          REG_TGL:     out_r     <= out_r ^ wdata;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    rd = '0;
    if (dp_valid && !dp_write) begin
      case (dp_idx)
        REG_OUT:     rd = out_r;
        REG_IN:      rd = in_sync;
        REG_DIR:     rd = dir_r;
        REG_MASK:    rd = mask_r;
        REG_RISE_EN: rd = rise_en_r;
        REG_FALL_EN: rd = fall_en_r;
        REG_PEND:    rd = pend_r;
        default:     rd = '0;
      endcase
    end
    HRDATA                 = '0;
    HRDATA[GPIO_WIDTH-1:0] = rd;
  end

  // Two-cycle ERROR response: wait state with HRESP high, then completion with HRESP high.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_OKAY;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          if (acc_err) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end else begin
            state     <= ST_OKAY;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign gpio_o    = out_r;
  assign gpio_oe_o = dir_r;

  assign unused_ok = ^{HBURST, HPROT, HADDR, HWDATA};

endmodule

// File: tb/tb_ahb3lite_gpio.sv
// tb/tb_ahb3lite_gpio.sv - scoreboard bench for ahb3lite_gpio
module tb_ahb3lite_gpio;
  import ahb3lite_gpio_pkg::*;

  localparam int W = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = '0;
  logic [31:0]   HWDATA = '0;
  logic [31:0]   HRDATA;
  logic          HWRITE = 1'b0;
  logic [2:0]    HSIZE = '0;
  logic [2:0]    HBURST = '0;
  logic [3:0]    HPROT = '0;
  logic [1:0]    HTRANS = '0;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [W-1:0]  gpio_i = '0;
  logic [W-1:0]  gpio_o;
  logic [W-1:0]  gpio_oe_o;
  logic          irq_o;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb3lite_gpio #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .GPIO_WIDTH(W), .SYNC_STAGES(2)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
  );

  typedef struct {
    bit          idle;
    bit          write;
    logic [3:0]  idx;
    logic [31:0] data;
    logic [2:0]  size;
    logic [1:0]  alo;
  } tx_t;

  typedef struct {
    bit          err;
    bit          rd;
    int          idx;
    logic [31:0] data;
  } exp_t;

  tx_t  txq[$];
  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference register state
  logic [W-1:0] m_out = '0, m_dir = '0, m_mask = '0, m_rise = '0, m_fall = '0, m_pend = '0, m_in = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  function automatic void edge_model(input logic [W-1:0] v);
    m_pend = m_pend | ((v & ~m_in) & m_rise) | ((~v & m_in) & m_fall);
    m_in   = v;
  endfunction

  function automatic void model_issue(input tx_t t);
    exp_t        e;
    logic [31:0] m;
    logic [W-1:0] d;
    int          nb, base;
    e.err  = (t.idx > 4'd9) || (t.write && t.idx == 4'd1);
    e.rd   = !t.write && !e.err;
    e.idx  = int'(t.idx);
    e.data = '0;
    if (e.rd) begin
      case (t.idx)
        4'd0: e.data = 32'(m_out);
        4'd1: e.data = 32'(m_in);
        4'd2: e.data = 32'(m_dir);
        4'd3: e.data = 32'(m_mask);
        4'd4: e.data = 32'(m_rise);
        4'd5: e.data = 32'(m_fall);
        4'd6: e.data = 32'(m_pend);
        default: e.data = '0;
      endcase
    end
    if (t.write && !e.err) begin
      nb   = 1 << int'(t.size);
      base = (int'(t.alo) / nb) * nb;
      m    = '0;
      for (int b = 0; b < 4; b++)
        if (b >= base && b < base + nb) m[8*b +: 8] = 8'hFF;
      d = W'(t.data & m);
      case (t.idx)
        4'd0: m_out  = (m_out & ~m[W-1:0]) | d;
        4'd2: m_dir  = (m_dir & ~m[W-1:0]) | d;
        4'd3: m_mask = (m_mask & ~m[W-1:0]) | d;
        4'd4: m_rise = (m_rise & ~m[W-1:0]) | d;
        4'd5: m_fall = (m_fall & ~m[W-1:0]) | d;
        4'd6: m_pend = m_pend & ~d;
        4'd7: m_out  = m_out | d;
        4'd8: m_out  = m_out & ~d;
        4'd9: m_out  = m_out ^ d;
        default: ;
      endcase
    end
    expq.push_back(e);
  endfunction

  task automatic push(input bit w, input int idx, input logic [31:0] d,
                      input int size = 2, input int alo = 0);
    tx_t t;
    t.idle = 1'b0; t.write = w; t.idx = 4'(idx); t.data = d;
    t.size = 3'(size); t.alo = 2'(alo);
    txq.push_back(t);
  endtask

  // Completes the current bus cycle, repeating while the slave inserts wait states.
  task automatic wait_ready();
    bit r;
    int n = 0;
    do begin
      @(negedge HCLK);
      r = HREADYOUT;
      @(posedge HCLK);
      #1;
      n++;
    end while (!r && n < 8);
    if (!r) begin
      n_checks++;
      n_fail++;
      $display("FAIL hreadyout_timeout: HREADYOUT low for %0d cycles, required release", n);
    end
  endtask

  // Pipelined master: address of each transfer overlaps the data phase of the previous one.
  task automatic run();
    tx_t         t;
    bit          pw = 1'b0;
    logic [31:0] pd = '0;
    while (txq.size() > 0) begin
      t = txq.pop_front();
      HWDATA = pw ? pd : $urandom;
      if (t.idle) begin
        HSEL   = 1'($urandom_range(0, 1));
        HTRANS = ($urandom_range(0, 1) != 0) ? HTRANS_BUSY : HTRANS_IDLE;
        HADDR  = $urandom;
        HWRITE = 1'($urandom_range(0, 1));
        HSIZE  = HSIZE_WORD;
        wait_ready();
        pw = 1'b0;
      end else begin
        model_issue(t);
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HADDR  = {26'd0, t.idx, t.alo};
        HWRITE = t.write;
        HSIZE  = t.size;
        wait_ready();
        pw = t.write;
        pd = t.data;
      end
    end
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HADDR  = $urandom;
    HWDATA = pw ? pd : $urandom;
    wait_ready();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Monitor: follows the bus, pops one expectation per completed data phase.
  initial begin : monitor
    bit   dp = 1'b0;
    bit   wresp = 1'b0;
    int   waits = 0;
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp = 1'b0;
        waits = 0;
      end else begin
        if (dp) begin
          if (!HREADYOUT) begin
            waits++;
            wresp = HRESP;
          end else begin
            if (expq.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL scoreboard_underflow: response seen, required none");
            end else begin
              e = expq.pop_front();
              check($sformatf("resp idx%0d {hresp,1wait,wait_hresp}", e.idx),
                    32'({HRESP, (waits == 1), (waits > 0 && wresp)}),
                    e.err ? 32'd7 : 32'd0);
              if (e.rd) check($sformatf("hrdata idx%0d", e.idx), HRDATA, e.data);
            end
            dp = 1'b0;
            waits = 0;
          end
        end
        if (HREADYOUT) dp = HSEL && HTRANS[1];
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int sz, alo;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst hrdata", HRDATA, 32'd0);
    check("rst hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst hresp", 32'(HRESP), 32'd0);
    check("rst gpio_o", 32'(gpio_o), 32'd0);
    check("rst gpio_oe_o", 32'(gpio_oe_o), 32'd0);
    check("rst irq_o", 32'(irq_o), 32'd0);
    HRESETn = 1'b1;
    cycles(1);

    for (int i = 0; i <= 6; i++) push(1'b0, i, '0);
    run();

    // Randomised traffic with static pins and no edges enabled
    gpio_i = W'($urandom);
    edge_model(gpio_i);
    cycles(4);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        tx_t t;
        t.idle = 1'b1; t.write = 1'b0; t.idx = '0; t.data = '0; t.size = '0; t.alo = '0;
        txq.push_back(t);
      end else begin
        sz  = int'($urandom_range(0, 2));
        alo = (sz == 0) ? int'($urandom_range(0, 3)) : (sz == 1) ? 2 * int'($urandom_range(0, 1)) : 0;
        push(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom, sz, alo);
      end
    end
    run();
    check("rand gpio_o", 32'(gpio_o), 32'(m_out));
    check("rand gpio_oe_o", 32'(gpio_oe_o), 32'(m_dir));
    check("rand irq_o", 32'(irq_o), 32'd0);

    push(1'b1, 4, 32'd0); push(1'b1, 5, 32'd0); push(1'b1, 3, 32'd0);
    push(1'b1, 6, 32'hFFFF_FFFF); push(1'b1, 2, 32'd0); push(1'b0, 6, '0);
    run();

    // Direction plus set/clear/toggle sequence
    push(1'b1, 2, 32'h0000_00FF); push(1'b1, 0, 32'h0000_00A5); push(1'b1, 7, 32'h0000_0002);
    push(1'b1, 8, 32'h0000_0080); push(1'b1, 9, 32'h0000_000F); push(1'b0, 0, '0);
    push(1'b0, 7, '0); push(1'b0, 8, '0); push(1'b0, 9, '0);
    run();
    check("sct gpio_o", 32'(gpio_o), 32'h0000_0028);
    check("sct gpio_oe_o", 32'(gpio_oe_o), 32'h0000_00FF);

    // Byte and halfword lane handling on a 16-bit port
    push(1'b1, 0, 32'h0000_1234); push(1'b1, 0, 32'h0000_5500, 0, 1); push(1'b0, 0, '0);
    run();
    check("byte lane1 gpio_o", 32'(gpio_o), 32'h0000_5534);
    push(1'b1, 0, 32'hABCD_0000, 1, 2); push(1'b1, 0, 32'h0000_0077, 0, 0); push(1'b0, 0, '0);
    run();
    check("upper half + byte0 gpio_o", 32'(gpio_o), 32'h0000_5577);

    // Rising edge on pin 0: PEND after SYNC_STAGES+1 cycles, irq one cycle later
    gpio_i = '0;
    edge_model(gpio_i);
    cycles(5);
    push(1'b1, 4, 32'h1); push(1'b1, 5, 32'h0); push(1'b1, 3, 32'h1);
    run();
    gpio_i = W'(1);
    edge_model(gpio_i);
    repeat (4) @(negedge HCLK);
    check("irq before pend latency", 32'(irq_o), 32'd0);
    @(negedge HCLK);
    check("irq after rise", 32'(irq_o), 32'd1);
    @(posedge HCLK);
    #1;
    push(1'b0, 1, '0); push(1'b0, 6, '0); push(1'b1, 6, 32'h1);
    run();
    @(negedge HCLK);
    check("irq held one cycle after w1c", 32'(irq_o), 32'd1);
    @(negedge HCLK);
    check("irq cleared after w1c", 32'(irq_o), 32'd0);
    @(posedge HCLK);
    #1;

    // W1C colliding with a fresh rising edge: the set must win
    gpio_i = '0; edge_model(gpio_i); cycles(5);
    gpio_i = W'(1); edge_model(gpio_i); cycles(6);
    check("irq re-armed", 32'(irq_o), 32'd1);
    gpio_i = '0; edge_model(gpio_i); cycles(6);
    gpio_i = W'(1);
    cycles(1);
    push(1'b1, 6, 32'h1);
    run();
    edge_model(gpio_i);
    push(1'b0, 6, '0);
    run();
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check($sformatf("irq kept on collision c%0d", i), 32'(irq_o), 32'd1);
    end
    @(posedge HCLK);
    #1;

    // ERROR responses, including back-to-back errors, then normal traffic
    push(1'b0, 12, '0); push(1'b1, 1, 32'h0000_FFFF); push(1'b0, 0, '0);
    push(1'b1, 2, 32'h0000_0F0F); push(1'b0, 2, '0); push(1'b0, 10, '0);
    push(1'b1, 15, 32'hFFFF_FFFF); push(1'b1, 1, 32'h1); push(1'b0, 1, '0);
    push(1'b0, 0, '0); push(1'b0, 3, '0);
    run();
    check("err gpio_o unchanged", 32'(gpio_o), 32'h0000_5577);
    check("err gpio_oe_o", 32'(gpio_oe_o), 32'h0000_0F0F);

    cycles(3);
    check("scoreboard drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
